// File: rtl/alu32_cmp_flags.sv
// rtl/alu32_cmp_flags.sv - two-stage EQ/NE/LTU/LT condition pipeline with equal-bit cross-check
module alu32_cmp_flags #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic             eq_in,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             cond,
    output logic [3:0]       flags,
    output logic             eq_err,
    output logic [CNT_W-1:0] eq_cnt
);

    // Stage 1 holds the split 16/16 unsigned compare so stage 2 only needs a few gates.
    logic       s1_valid;
    logic [1:0] s1_op;
    logic       s1_eq;
    logic       s1_sx;
    logic       s1_sy;
    logic       s1_hi_eq;
    logic       s1_hi_lt;
    logic       s1_lo_lt;

    logic       s2_valid;
    logic       advance;
    logic       accept;

    logic       c_eq;
    logic       c_ne;
    logic       c_ltu;
    logic       c_lt;
    logic       c_cond;

    // s2 can take a new beat when empty or draining; s1 frees up on the same condition.
    assign advance   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | advance;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;

    // Stage 1: capture operands' partial compares on every accept.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 2'b00;
            s1_eq    <= 1'b0;
            s1_sx    <= 1'b0;
            s1_sy    <= 1'b0;
            s1_hi_eq <= 1'b0;
            s1_hi_lt <= 1'b0;
            s1_lo_lt <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= op;
                s1_eq    <= eq_in;
                s1_sx    <= x[31];
                s1_sy    <= y[31];
                s1_hi_eq <= (x[31:16] == y[31:16]);
                s1_hi_lt <= (x[31:16] <  y[31:16]);
                s1_lo_lt <= (x[15:0]  <  y[15:0]);
            end
        end
    end

    // Combine the half-word compares; signed LT differs from LTU only when the signs differ.
    always_comb begin
        c_eq  = s1_eq;
        c_ne  = ~s1_eq;
        c_ltu = s1_hi_lt | (s1_hi_eq & s1_lo_lt);
        c_lt  = (s1_sx != s1_sy) ? s1_sx : c_ltu;
        case (s1_op)
            2'b00:   c_cond = c_eq;
            2'b01:   c_cond = c_ne;
            2'b10:   c_cond = c_ltu;
            default: c_cond = c_lt;
        endcase
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            s2_valid <= 1'b0;
            flags    <= 4'b0000;
            cond     <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                flags <= {c_lt, c_ltu, c_ne, c_eq};
                cond  <= c_cond;
            end
        end
    end

    // Sticky disagreement flag and saturating equal-beat counter, both updated at accept.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            eq_err <= 1'b0;
            eq_cnt <= '0;
        end else if (accept) begin
            if (eq_in != (x == y)) begin
                eq_err <= 1'b1;
            end
            if (eq_in && (eq_cnt != {CNT_W{1'b1}})) begin
                eq_cnt <= eq_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu32_cmp_flags.sv
// tb/tb_alu32_cmp_flags.sv - scoreboard bench for alu32_cmp_flags
module tb_alu32_cmp_flags;

    localparam int CNT_W = 2;

    logic             clk;
    logic             n_rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      x;
    logic [31:0]      y;
    logic             eq_in;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             cond;
    logic [3:0]       flags;
    logic             eq_err;
    logic [CNT_W-1:0] eq_cnt;

    alu32_cmp_flags #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .eq_in     (eq_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cond      (cond),
        .flags     (flags),
        .eq_err    (eq_err),
        .eq_cnt    (eq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [4:0]       exp_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_err = 1'b0;
    logic             saw_bp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every emit; check hold-stable behaviour under stall.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_flags = '0;
    logic       prev_cond  = 1'b0;
    logic [4:0] e;
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_flags", {28'd0, flags}, {28'd0, prev_flags});
                chk("stall_cond", {31'd0, cond}, {31'd0, prev_cond});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: flags=%b with empty scoreboard", flags);
                end else begin
                    e = exp_q.pop_front();
                    chk("flags", {28'd0, flags}, {28'd0, e[4:1]});
                    chk("cond", {31'd0, cond}, {31'd0, e[0]});
                    n_out++;
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_flags = flags;
            prev_cond  = cond;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ei,
                        input logic [1:0] o, input logic [3:0] ef, input logic ec);
        bit done;
        done     = 1'b0;
        x        = a;
        y        = b;
        eq_in    = ei;
        op       = o;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ef, ec});
                if (ei && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
                if (ei != (a == b)) m_err = 1'b1;
                done = 1'b1;
            end else begin
                saw_bp = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end else begin
            chk("eq_cnt", {30'd0, eq_cnt}, {30'd0, m_cnt});
            chk("eq_err", {31'd0, eq_err}, {31'd0, m_err});
        end
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results left expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    initial begin
        n_rst     = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        eq_in     = 1'b0;
        op        = 2'b00;
        out_ready = 1'b1;

        // reset with in_valid held high
        in_valid = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_eq_err", {31'd0, eq_err}, 32'd0);
        chk("rst_eq_cnt", {30'd0, eq_cnt}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // signed vs unsigned, plus latency
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b11, 4'b1010, 1'b1);
        chk("lat_s1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_s2", {31'd0, out_valid}, 32'd1);
        drain();

        // high halves equal, low halves decide
        send(32'h1234_0001, 32'h1234_0002, 1'b0, 2'b10, 4'b1110, 1'b1);
        drain();

        // back-to-back with consumer stall
        out_ready = 1'b0;
        saw_bp    = 1'b0;
        fork
            begin
                send(32'h0000_0005, 32'h0000_0005, 1'b1, 2'b00, 4'b0001, 1'b1);
                send(32'h0000_0001, 32'h0000_0002, 1'b0, 2'b01, 4'b1110, 1'b1);
                send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2'b10, 4'b1010, 1'b0);
                send(32'h0001_0000, 32'h0000_FFFF, 1'b0, 2'b11, 4'b0010, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("backpressure_seen", {31'd0, saw_bp}, 32'd1);
        chk("results_in_order", n_out, 32'd6);

        // external equal bit disagrees; sticky afterwards
        send(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2'b00, 4'b0010, 1'b0);
        chk("err_set", {31'd0, eq_err}, 32'd1);
        send(32'h0000_0003, 32'h0000_0003, 1'b1, 2'b00, 4'b0001, 1'b1);
        chk("err_sticky", {31'd0, eq_err}, 32'd1);
        drain();

        // counter saturation with CNT_W=2
        do_reset();
        n_rst = 1'b1;
        chk("rst2_eq_err", {31'd0, eq_err}, 32'd0);
        chk("rst2_eq_cnt", {30'd0, eq_cnt}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            send(32'h0000_0007, 32'h0000_0007, 1'b1, 2'b00, 4'b0001, 1'b1);
        end
        chk("cnt_sat", {30'd0, eq_cnt}, 32'd3);
        drain();

        // reset with beats in flight
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 2'b10, 4'b1110, 1'b1);
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 2'b10, 4'b1110, 1'b1);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_cnt = '0;
        m_err = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_eq_cnt", {30'd0, eq_cnt}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        n_rst     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(32'h0000_0002, 32'h0000_0001, 1'b0, 2'b01, 4'b0010, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
